// File: rtl/demux1to16_deser.sv
// 1-to-N serial demultiplexer / deserializer: steers each valid bit into fill
// position sel and publishes the assembled word when position N-1 is written.
module demux1to16_deser #(
  parameter int N     = 16,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             load_sel,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     out,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  logic [N-1:0]     fill;
  logic [SEL_W-1:0] p;
  logic             last_write;

  always_comb begin
    p          = load_sel ? sel_in : sel;
    last_write = in_valid && (p == LAST);
  end

  // sel, out_valid and busy depend only on control inputs, never on the data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= '0;
      fill      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= last_write;
      if (in_valid) begin
        fill[p] <= in;
        sel     <= p + SEL_W'(1);
        busy    <= !last_write;
        if (last_write)
          out <= {in, fill[N-2:0]};
      end else if (load_sel) begin
        sel <= sel_in;
      end
    end
  end

endmodule

// File: tb/tb_demux1to16_deser.sv
// Directed self-checking bench for demux1to16_deser: reset, round trip,
// back-to-back words, gapped input, addressed write and mid-word reset.
module tb_demux1to16_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in;
  logic        in_valid;
  logic        load_sel;
  logic [3:0]  sel_in;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  demux1to16_deser #(.N(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .load_sel  (load_sel),
    .sel_in    (sel_in),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends a word LSB-first with no gaps; checks the strobe stays low until bit 15.
  task automatic send_word(input logic [15:0] w, input logic [15:0] held);
    for (int i = 0; i < 16; i++) begin
      in       = w[i];
      in_valid = 1'b1;
      step();
      if (i < 15) begin
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_out_held", 32'(out), 32'(held));
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    int          t0;
    int          t1;
    int          gap;

    rst = 1'b1; in = 1'b0; in_valid = 1'b0; load_sel = 1'b0; sel_in = '0;

    // 1: reset
    step(); step();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // 2: round trip with per-bit pointer and busy tracking
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      in = w[i]; in_valid = 1'b1;
      step();
      if (i < 15) begin
        check("rt_sel", 32'(sel), 32'(i + 1));
        check("rt_busy", 32'(busy), 32'd1);
        check("rt_out_valid_low", 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    check("rt_out", 32'(out), 32'hA5C3);
    check("rt_out_valid", 32'(out_valid), 32'd1);
    check("rt_sel_wrap", 32'(sel), 32'd0);
    check("rt_busy_clear", 32'(busy), 32'd0);
    step();
    check("rt_strobe_1cyc", 32'(out_valid), 32'd0);
    check("rt_out_hold", 32'(out), 32'hA5C3);

    // 3: back-to-back words
    send_word(16'h1234, 16'hA5C3);
    t0 = cycle;
    check("b2b_out1", 32'(out), 32'h1234);
    check("b2b_valid1", 32'(out_valid), 32'd1);
    send_word(16'hFFFF, 16'h1234);
    t1 = cycle;
    check("b2b_out2", 32'(out), 32'hFFFF);
    check("b2b_valid2", 32'(out_valid), 32'd1);
    check("b2b_spacing", 32'(t1 - t0), 32'd16);

    // 4: random gaps; sel must hold while in_valid is low
    w = 16'h5A3C;
    for (int i = 0; i < 16; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0; in = 1'($urandom_range(0, 1));
        step();
        check("gap_sel_hold", 32'(sel), 32'(i));
        check("gap_no_strobe", 32'(out_valid), 32'd0);
      end
      in = w[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("gap_out", 32'(out), 32'h5A3C);
    check("gap_valid", 32'(out_valid), 32'd1);

    // 5: load_sel alone, then addressed write to position 15
    send_word(16'h0000, 16'h5A3C);
    check("zero_out", 32'(out), 32'h0000);
    load_sel = 1'b1; sel_in = 4'd5;
    step();
    check("load_sel_val", 32'(sel), 32'd5);
    check("load_busy_unchanged", 32'(busy), 32'd0);
    check("load_no_strobe", 32'(out_valid), 32'd0);
    load_sel = 1'b0;
    step();
    check("load_hold", 32'(sel), 32'd5);
    load_sel = 1'b1; sel_in = 4'd15; in_valid = 1'b1; in = 1'b1;
    step();
    load_sel = 1'b0; in_valid = 1'b0; in = 1'b0;
    check("addr_out", 32'(out), 32'h8000);
    check("addr_valid", 32'(out_valid), 32'd1);
    check("addr_sel", 32'(sel), 32'd0);
    check("addr_busy", 32'(busy), 32'd0);

    // 6: reset after 7 bits discards the partial word
    for (int i = 0; i < 7; i++) begin
      in = 1'b1; in_valid = 1'b1;
      step();
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_sel", 32'(sel), 32'd7);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    send_word(16'h00FF, 16'h0000);
    check("midrst_final_out", 32'(out), 32'h00FF);
    check("midrst_final_valid", 32'(out_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
